// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: steps a round-10 key back to round 0, one round key per accepted transfer.
// Optional sticky misuse flag `err` when INV_KEY_SCHEDULE_ERR_EN is defined.
module inv_key_schedule #(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [vecSize-1:0][regSize-1:0] key_in,
  input  logic                             key_ready,
  output logic                             key_valid,
  output logic [vecSize-1:0][regSize-1:0] round_key,
  output logic [3:0]                       round_idx,
  output logic                             busy,
  output logic                             done
`ifdef INV_KEY_SCHEDULE_ERR_EN
  ,
  output logic                             err
`endif
);

  typedef logic [vecSize-1:0][regSize-1:0] key_t;
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Undo one forward expansion step: round r key -> round r-1 key.
  function automatic key_t inv_step(input key_t k, input logic [3:0] r);
    key_t n;
    n[3] = k[3] ^ k[2];
    n[2] = k[2] ^ k[1];
    n[1] = k[1] ^ k[0];
    n[0] = k[0] ^ sub_word(rot_word(n[3])) ^ {rcon(r), 24'h0};
    return n;
  endfunction

  state_t      state_q, state_d;
  key_t        round_key_q, round_key_d;
  logic [3:0]  round_idx_q, round_idx_d;
  logic        done_q, done_d;
  logic        xfer;

  assign xfer = (state_q == EMIT) && key_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EMIT;
      EMIT:    if (xfer && (round_idx_q == 4'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_valid = (state_q == EMIT);
    busy      = (state_q == EMIT);
  end

  always_comb begin
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    done_d      = 1'b0;
    if ((state_q == IDLE) && start) begin
      round_key_d = key_in;
      round_idx_d = 4'd10;
    end else if (xfer) begin
      if (round_idx_q == 4'd0) begin
        done_d = 1'b1;
      end else begin
        round_key_d = inv_step(round_key_q, round_idx_q);
        round_idx_d = round_idx_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_key_q <= '0;
      round_idx_q <= 4'd0;
      done_q      <= 1'b0;
    end else begin
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      done_q      <= done_d;
    end
  end

  assign round_key = round_key_q;
  assign round_idx = round_idx_q;
  assign done      = done_q;

`ifdef INV_KEY_SCHEDULE_ERR_EN
  logic err_q, err_d;

  // Sticky: any start request while a sequence is in flight.
  assign err_d = err_q | (start && (state_q == EMIT));

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
